// File: rtl/conv_cache_drain_ctrl.sv
// Drain controller for the convolution output cache: holds the head entry, then writes it out via req/gnt.
// Optional statistics counters are enabled by defining CONV_DRAIN_STATS_EN.
module conv_cache_drain_ctrl #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned AGE_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cache_full,
  input  logic        cache_valid,
  input  logic [16:0] cache_addr,
  input  logic [31:0] cache_data,
  input  logic [3:0]  cache_web,
  output logic        cache_deq,
  output logic        eng_stall,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [16:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_web,
  input  logic        flush_req,
  output logic        flush_done,
  output logic [15:0] stat_words,
  output logic [15:0] stat_stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    REQ  = 2'd2
  } state_e;

  localparam logic [AGE_W-1:0] HOLD_AGE = AGE_W'(HOLD_CYCLES);
  localparam logic [AGE_W-1:0] AGE_MAX  = '1;

  state_e            state_q;
  logic [AGE_W-1:0]  age_q;
  logic [AGE_W-1:0]  age_d;
  logic              flush_pend_q;
  logic              busy_q;
  logic              mem_req_q;
  logic [16:0]       mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        mem_web_q;
  logic              drain_start;
  logic              flush_fire;

  assign drain_start = (state_q == IDLE) && cache_valid &&
                       ((age_q == HOLD_AGE) || cache_full || flush_pend_q);
  assign flush_fire  = flush_pend_q && (state_q == IDLE) && !cache_valid;

  // The grant cycle is the dequeue cycle, so deq is decoded from the registered request.
  assign cache_deq  = mem_req_q & mem_gnt;
  assign eng_stall  = cache_full | busy_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_web    = mem_web_q;
  assign flush_done = flush_fire;

  always_comb begin
    age_d = age_q;
    if (!cache_valid || (state_q != IDLE) || cache_deq) begin
      age_d = '0;
    end else if (age_q != AGE_MAX) begin
      age_d = age_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      age_q        <= '0;
      flush_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_web_q    <= 4'hF;
    end else begin
      age_q <= age_d;

      if (flush_fire) begin
        flush_pend_q <= 1'b0;
      end else if (flush_req) begin
        flush_pend_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (drain_start) begin
            state_q <= LOCK;
            busy_q  <= 1'b1;
          end
        end
        // The engine is stalled for all of LOCK, so the head is stable when sampled here.
        LOCK: begin
          state_q     <= REQ;
          mem_req_q   <= 1'b1;
          mem_addr_q  <= cache_addr;
          mem_wdata_q <= cache_data;
          mem_web_q   <= cache_web;
        end
        REQ: begin
          if (mem_gnt) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONV_DRAIN_STATS_EN
  logic [15:0] stat_words_q;
  logic [15:0] stat_stall_q;

  // Word count wraps; stall count saturates so long runs stay meaningful.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_words_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (cache_deq) begin
        stat_words_q <= stat_words_q + 16'd1;
      end
      if (eng_stall && (stat_stall_q != 16'hFFFF)) begin
        stat_stall_q <= stat_stall_q + 16'd1;
      end
    end
  end

  assign stat_words = stat_words_q;
  assign stat_stall = stat_stall_q;
`else
  assign stat_words = '0;
  assign stat_stall = '0;
`endif

endmodule
